dm_responder: RTL and testbench

Responder side of the CPU data-memory port: accepts one load/store request at a time from the core's memory stage and answers after a fixed, parameterised latency. It replaces the zero-latency data memory so the single-cycle core can be moved to a stalled or multi-cycle memory model. It owns word-addressed storage with byte and halfword lane handling, using the same size encoding as the core's write-width control. It also flags misaligned or out-of-range accesses.

---
 rtl/dm_responder_if.sv | 25 ++
 rtl/dm_responder.sv | 169 ++++++++++++++++
 tb/tb_dm_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/dm_responder_if.sv
// Request/response bus between the core memory stage (master) and the
// data-memory responder (slave).
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_responder.sv
// Fixed-latency data-memory responder: word storage with byte/half lanes,
// one outstanding request, stores commit at acceptance, loads answered in RESP.
module dm_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic         clk,
    input  logic         reset,
    dm_responder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              accept;
    logic              enter_resp;
    logic              req_err_c;
    logic [ADDR_W-1:0] req_idx_c;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    logic              we_p0, sgn_p0, err_p0;
    logic [1:0]        size_p0, lane_p0;
    logic [ADDR_W-1:0] idx_p0;

    logic              src_we, src_sgn, src_err;
    logic [1:0]        src_size, src_lane;
    logic [ADDR_W-1:0] src_idx;
    logic [31:0]       load_val, rdata_nxt;
    logic [31:0]       rdata_q;
    logic              err_q;

    function automatic logic req_illegal(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        case (size)
            2'b00:   bad = (addr[1:0] != 2'b00);
            2'b01:   bad = addr[0];
            2'b10:   bad = 1'b0;
            default: bad = 1'b1;
        endcase
        if ((addr >> (ADDR_W + 2)) != 32'd0) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic sgn);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
            2'b10:   r = sgn ? {{24{b[7]}}, b} : {24'h000000, b};
            default: r = word;
        endcase
        return r;
    endfunction

    assign req_err_c = req_illegal(bus.req_size, bus.req_addr);
    assign req_idx_c = bus.req_addr[ADDR_W+1:2];
    assign accept    = reset && (state == IDLE) && bus.req_valid;

    // With LATENCY=1 the response is built on the acceptance edge itself,
    // so the live request fields stand in for the not-yet-captured ones.
    always_comb begin
        if (state == IDLE) begin
            src_we   = bus.req_we;
            src_sgn  = bus.req_signed;
            src_err  = req_err_c;
            src_size = bus.req_size;
            src_lane = bus.req_addr[1:0];
            src_idx  = req_idx_c;
        end else begin
            src_we   = we_p0;
            src_sgn  = sgn_p0;
            src_err  = err_p0;
            src_size = size_p0;
            src_lane = lane_p0;
            src_idx  = idx_p0;
        end
    end

    assign load_val  = lane_extract(mem[src_idx], src_lane, src_size, src_sgn);
    assign rdata_nxt = (src_we || src_err) ? 32'd0 : load_val;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        enter_resp    = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (LATENCY > 1) begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(LATENCY - 1);
                    end else begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_nxt  = RESP;
                    cnt_nxt    = 4'd0;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (enter_resp) begin
                rdata_q <= rdata_nxt;
                err_q   <= src_err;
            end
        end
    end

    // Acceptance stage: capture the request so later input changes are ignored
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0   <= bus.req_we;
            sgn_p0  <= bus.req_signed;
            err_p0  <= req_err_c;
            size_p0 <= bus.req_size;
            lane_p0 <= bus.req_addr[1:0];
            idx_p0  <= req_idx_c;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_err_c) begin
            case (bus.req_size)
                2'b00: mem[req_idx_c] <= bus.req_wdata;
                2'b01: begin
                    if (bus.req_addr[1]) mem[req_idx_c][31:16] <= bus.req_wdata[15:0];
                    else                 mem[req_idx_c][15:0]  <= bus.req_wdata[15:0];
                end
                2'b10: mem[req_idx_c][{bus.req_addr[1:0], 3'b000} +: 8] <= bus.req_wdata[7:0];
                default: ;
            endcase
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: LATENCY=2 instance for function/errors/reset,
// LATENCY=1 instance for back-to-back throughput.
module tb_dm_responder;

    localparam int LAT_A = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dm_responder_if ifa();
    dm_responder_if ifb();

    dm_responder #(.ADDR_W(10), .LATENCY(LAT_A)) u_dut  (.clk(clk), .reset(reset), .bus(ifa));
    dm_responder #(.ADDR_W(10), .LATENCY(1))     u_dut1 (.clk(clk), .reset(reset), .bus(ifb));

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
        ifa.req_valid  = 1'b1;
        ifa.req_we     = we;
        ifa.req_size   = size;
        ifa.req_signed = sgn;
        ifa.req_addr   = addr;
        ifa.req_wdata  = wdata;
    endtask

    task automatic scramble_a(input logic we, input logic sgn, input logic [31:0] addr,
                              input logic [31:0] wdata);
        ifa.req_valid  = 1'b0;
        ifa.req_we     = ~we;
        ifa.req_size   = 2'b11;
        ifa.req_signed = ~sgn;
        ifa.req_addr   = 32'hFFFF_FFFF ^ addr;
        ifa.req_wdata  = ~wdata;
    endtask

    task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_d, input logic exp_e, input int hold = 0);
        exp_t e;
        int   lat;
        sb.push_back('{rdata: exp_d, err: exp_e});
        drive_a(we, size, sgn, addr, wdata);
        lat = 0;
        while (!ifa.req_ready && lat < 20) begin cyc(); lat++; end
        chk({tag, "/ready"}, 32'(ifa.req_ready), 32'd1);
        cyc();
        scramble_a(we, sgn, addr, wdata);
        lat = 0;
        while (!ifa.rsp_valid && lat < 20) begin cyc(); lat++; end
        chk({tag, "/lat"}, 32'(lat), 32'(LAT_A - 1));
        e = sb.pop_front();
        chk({tag, "/rdata"}, ifa.rsp_rdata, e.rdata);
        chk({tag, "/err"}, 32'(ifa.rsp_err), 32'(e.err));
        chk({tag, "/busy"}, 32'(ifa.req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            cyc();
            chk({tag, "/hold_valid"}, 32'(ifa.rsp_valid), 32'd1);
            chk({tag, "/hold_rdata"}, ifa.rsp_rdata, e.rdata);
            chk({tag, "/hold_err"}, 32'(ifa.rsp_err), 32'(e.err));
            chk({tag, "/hold_ready"}, 32'(ifa.req_ready), 32'd0);
        end
        ifa.rsp_ready = 1'b1;
        cyc();
        ifa.rsp_ready = 1'b0;
        chk({tag, "/done"}, 32'({ifa.rsp_valid, ifa.req_ready}), 32'b01);
    endtask

    task automatic abort_in_wait(input string tag, input logic we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        int lat;
        drive_a(we, size, 1'b0, addr, wdata);
        lat = 0;
        while (!ifa.req_ready && lat < 20) begin cyc(); lat++; end
        cyc();
        scramble_a(we, 1'b0, addr, wdata);
        chk({tag, "/in_wait"}, 32'({ifa.rsp_valid, ifa.req_ready}), 32'b00);
        reset = 1'b0;
        #2;
        chk({tag, "/async"}, 32'({ifa.rsp_valid, ifa.req_ready}), 32'b01);
        cyc(2);
        reset = 1'b1;
        cyc(3);
        chk({tag, "/after_valid"}, 32'(ifa.rsp_valid), 32'd0);
        chk({tag, "/after_ready"}, 32'(ifa.req_ready), 32'd1);
    endtask

    task automatic drive_b(input int k);
        ifb.req_valid  = 1'b1;
        ifb.req_signed = 1'b0;
        ifb.req_wdata  = 32'd0;
        ifb.req_we     = 1'b0;
        case (k)
            0: begin
                ifb.req_we = 1'b1; ifb.req_size = 2'b00; ifb.req_addr = 32'h20;
                ifb.req_wdata = 32'h8899_AABB;
                sb.push_back('{rdata: 32'd0, err: 1'b0});
            end
            1: begin
                ifb.req_size = 2'b00; ifb.req_addr = 32'h20;
                sb.push_back('{rdata: 32'h8899_AABB, err: 1'b0});
            end
            2: begin
                ifb.req_size = 2'b10; ifb.req_addr = 32'h21;
                sb.push_back('{rdata: 32'h0000_00AA, err: 1'b0});
            end
            default: begin
                ifb.req_size = 2'b01; ifb.req_signed = 1'b1; ifb.req_addr = 32'h22;
                sb.push_back('{rdata: 32'hFFFF_8899, err: 1'b0});
            end
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   k;
        int   last;
        ifa.req_valid = 1'b0; ifa.req_we = 1'b0; ifa.req_size = 2'b00; ifa.req_signed = 1'b0;
        ifa.req_addr  = 32'd0; ifa.req_wdata = 32'd0; ifa.rsp_ready = 1'b0;
        ifb.req_valid = 1'b0; ifb.req_we = 1'b0; ifb.req_size = 2'b00; ifb.req_signed = 1'b0;
        ifb.req_addr  = 32'd0; ifb.req_wdata = 32'd0; ifb.rsp_ready = 1'b0;

        reset = 1'b0;
        cyc(3);
        chk("rst/ready_in_reset", 32'(ifa.req_ready), 32'd1);
        reset = 1'b1;
        cyc();
        chk("rst/req_ready", 32'(ifa.req_ready), 32'd1);
        chk("rst/rsp_valid", 32'(ifa.rsp_valid), 32'd0);
        chk("rst/rsp_rdata", ifa.rsp_rdata, 32'd0);
        chk("rst/rsp_err", 32'(ifa.rsp_err), 32'd0);

        xact("st_w",    1'b1, 2'b00, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0);
        xact("ld_w",    1'b0, 2'b00, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0);
        xact("st_b",    1'b1, 2'b10, 1'b0, 32'h13, 32'h0000_0080, 32'h0000_0000, 1'b0);
        xact("ld_w2",   1'b0, 2'b00, 1'b0, 32'h10, 32'h0,         32'h80AD_BEEF, 1'b0);
        xact("ld_bs",   1'b0, 2'b10, 1'b1, 32'h13, 32'h0,         32'hFFFF_FF80, 1'b0);
        xact("ld_bu",   1'b0, 2'b10, 1'b0, 32'h13, 32'h0,         32'h0000_0080, 1'b0);
        xact("ld_hs",   1'b0, 2'b01, 1'b1, 32'h12, 32'h0,         32'hFFFF_80AD, 1'b0);
        xact("st_h",    1'b1, 2'b01, 1'b0, 32'h10, 32'h1234_A5A5, 32'h0000_0000, 1'b0);
        xact("ld_hu",   1'b0, 2'b01, 1'b0, 32'h10, 32'h0,         32'h0000_A5A5, 1'b0);
        xact("ld_bu1",  1'b0, 2'b10, 1'b0, 32'h11, 32'h0,         32'h0000_00A5, 1'b0);
        xact("st_mis",  1'b1, 2'b00, 1'b0, 32'h12, 32'h5555_5555, 32'h0000_0000, 1'b1);
        xact("ld_bp",   1'b0, 2'b00, 1'b0, 32'h10, 32'h0,         32'h80AD_A5A5, 1'b0, 5);
        xact("ld_oor",  1'b0, 2'b00, 1'b0, 32'h1000, 32'h0,       32'h0000_0000, 1'b1);
        xact("ld_sz3",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0,         32'h0000_0000, 1'b1);
        xact("ld_hmis", 1'b0, 2'b01, 1'b1, 32'h11, 32'h0,         32'h0000_0000, 1'b1);
        xact("st_oor",  1'b1, 2'b00, 1'b0, 32'h1010, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        xact("ld_w3",   1'b0, 2'b00, 1'b0, 32'h10, 32'h0,         32'h80AD_A5A5, 1'b0);

        abort_in_wait("ab_st", 1'b1, 2'b00, 32'h44, 32'h1234_5678);
        abort_in_wait("ab_ld", 1'b0, 2'b00, 32'h10, 32'h0);
        xact("ld_after", 1'b0, 2'b00, 1'b0, 32'h44, 32'h0, 32'h1234_5678, 1'b0);

        ifb.rsp_ready = 1'b1;
        k    = 0;
        last = -1;
        for (int c = 0; c < 24 && !(k == 4 && sb.size() == 0); c++) begin
            if (ifb.rsp_valid) begin
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("b/rdata", ifb.rsp_rdata, e.rdata);
                    chk("b/err", 32'(ifb.rsp_err), 32'(e.err));
                    chk("b/no_accept_in_resp", 32'(ifb.req_ready), 32'd0);
                end else begin
                    chk("b/spurious_rsp", 32'(ifb.rsp_valid), 32'd0);
                end
            end
            if (ifb.req_ready) begin
                if (k < 4) begin
                    if (k > 0) chk("b/gap", 32'(c - last), 32'd2);
                    last = c;
                    drive_b(k);
                    k++;
                end else begin
                    ifb.req_valid = 1'b0;
                end
            end
            cyc();
        end
        ifb.req_valid = 1'b0;
        ifb.rsp_ready = 1'b0;
        chk("b/accepted", 32'(k), 32'd4);
        chk("b/drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
